// File: rtl/output_requant_fifo.sv
// output_requant_fifo
//   Output stage of the conv accelerator. It takes each accumulator result and its (x,y,ch)
//   tag and requantises the value to IO_DATA_WIDTH: a rounding arithmetic right shift, an
//   optional ReLU, then signed saturation. Each result is registered once (stage P1) and
//   then buffered in a first-word-fall-through FIFO. The host drains the FIFO over a
//   valid/ready handshake.
// Ports
//   clk, arst_in           clock; asynchronous active-high reset
//   clear                  synchronous flush of pipe, FIFO, overflow and sat_count
//   in_valid, in_data      accumulator sample (signed ACC_WIDTH)
//   in_x, in_y, in_ch      sample tags, passed through unchanged
//   stall_req              asks the controller to pause issuing samples (level >= DEPTH-2)
//   out_valid, out_ready   head handshake; a pop happens on out_valid && out_ready
//   out_data, out_x/y/ch   head entry (the last popped entry while the FIFO is empty)
//   level                  FIFO occupancy, 0..FIFO_DEPTH
//   overflow               sticky: a sample was dropped because the FIFO was full
//   sat_count              saturating count of clipped samples
module output_requant_fifo #(
  parameter int ACC_WIDTH     = 32,
  parameter int IO_DATA_WIDTH = 16,
  parameter int OUTPUT_SCALE  = 0,
  parameter int RELU_EN       = 0,
  parameter int FIFO_DEPTH    = 8,
  parameter int X_WIDTH       = 10,
  parameter int Y_WIDTH       = 10,
  parameter int CH_WIDTH      = 6
) (
  input  logic                          clk,
  input  logic                          arst_in,
  input  logic                          clear,
  input  logic                          in_valid,
  input  logic [ACC_WIDTH-1:0]          in_data,
  input  logic [X_WIDTH-1:0]            in_x,
  input  logic [Y_WIDTH-1:0]            in_y,
  input  logic [CH_WIDTH-1:0]           in_ch,
  output logic                          stall_req,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [IO_DATA_WIDTH-1:0]      out_data,
  output logic [X_WIDTH-1:0]            out_x,
  output logic [Y_WIDTH-1:0]            out_y,
  output logic [CH_WIDTH-1:0]           out_ch,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic [15:0]                   sat_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = IO_DATA_WIDTH + X_WIDTH + Y_WIDTH + CH_WIDTH;
  localparam logic [IO_DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(IO_DATA_WIDTH-1){1'b1}}};
  localparam logic [IO_DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(IO_DATA_WIDTH-1){1'b0}}};

  // Requantisation, carried at ACC_WIDTH+1 bits so the rounding add cannot wrap
  logic signed [ACC_WIDTH:0]          acc_ext;
  logic signed [ACC_WIDTH:0]          t_shift;
  logic signed [ACC_WIDTH:0]          t_relu;
  logic [ACC_WIDTH-IO_DATA_WIDTH+1:0] upper;
  logic [IO_DATA_WIDTH-1:0]           req_data;
  logic                               clip;

  assign acc_ext = {in_data[ACC_WIDTH-1], in_data};

  generate
    if (OUTPUT_SCALE > 0) begin : g_round
      localparam logic signed [ACC_WIDTH:0] ROUND_HALF =
        $signed({{ACC_WIDTH{1'b0}}, 1'b1}) <<< (OUTPUT_SCALE - 1);
      logic signed [ACC_WIDTH:0] sum;
      assign sum     = acc_ext + ROUND_HALF;
      assign t_shift = sum >>> OUTPUT_SCALE;
    end else begin : g_pass
      assign t_shift = acc_ext;
    end
  endgenerate

  assign t_relu = (RELU_EN != 0 && t_shift[ACC_WIDTH]) ? '0 : t_shift;

  // The value fits in IO_DATA_WIDTH only when every bit from the output sign bit upward
  // matches that sign bit.
  assign upper = t_relu[ACC_WIDTH:IO_DATA_WIDTH-1];

  always_comb begin
    req_data = t_relu[IO_DATA_WIDTH-1:0];
    clip     = 1'b0;
    if (!(&upper) && (|upper)) begin
      clip     = 1'b1;
      req_data = t_relu[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end

  // Stage P1
  logic             p1_valid;
  logic [ENT_W-1:0] p1_entry;

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      p1_valid  <= 1'b0;
      p1_entry  <= '0;
      sat_count <= '0;
    end else if (clear) begin
      p1_valid  <= 1'b0;
      p1_entry  <= '0;
      sat_count <= '0;
    end else begin
      p1_valid <= in_valid;
      if (in_valid) begin
        p1_entry <= {req_data, in_x, in_y, in_ch};
        if (clip && sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
      end
    end
  end

  // FIFO
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [ENT_W-1:0] last_entry;
  logic [ENT_W-1:0] out_entry;
  logic             full;
  logic             pop;
  logic             wr_en;

  assign full      = (level == LVL_W'(FIFO_DEPTH));
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  // At full, a same-cycle pop frees the head slot, which is the slot wr_ptr points to.
  assign wr_en     = p1_valid && !clear && (!full || pop);
  assign stall_req = (level >= LVL_W'(FIFO_DEPTH - 2));

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= p1_entry;
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      last_entry <= '0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      last_entry <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        last_entry <= mem[rd_ptr];
      end
      if (wr_en && !pop)      level <= level + LVL_W'(1);
      else if (!wr_en && pop) level <= level - LVL_W'(1);
      if (p1_valid && full && !pop) overflow <= 1'b1;
    end
  end

  // While the FIFO is empty, the outputs show the last popped entry, which is zero after
  // reset or clear.
  assign out_entry = out_valid ? mem[rd_ptr] : last_entry;
  assign {out_data, out_x, out_y, out_ch} = out_entry;

endmodule
